lcd_pclk_gen: RTL and testbench

Parametrised LCD pixel-clock generator, successor to the fixed divide-by-2 pixel-clock divider. It produces `lcd_pclk` from the system clock with a divide ratio selectable at run time, including odd ratios. Ratio changes are glitch-free and take effect only at period boundaries. A start/stop enable is provided, along with one-cycle rise/fall strobes in the `clk` domain for the LCD timing and data logic. It sits between the system clock and the LCD timing controller.

---
 rtl/lcd_pclk_gen.sv | 156 +++++++++++++++
 tb/tb_lcd_pclk_gen.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_pclk_gen.sv
// lcd_pclk_gen
// Run-time programmable LCD pixel-clock divider. Produces a registered,
// glitch-free lcd_pclk with period N clk cycles (high ceil(N/2), low
// floor(N/2)). It also produces rise/fall strobes in the clk domain and
// applies ratio changes only at period boundaries.
module lcd_pclk_gen #(
   parameter int DIV_W       = 8,
   parameter int DEFAULT_DIV = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [DIV_W-1:0] div_in,
   input  logic             div_load,
   output logic             lcd_pclk,
   output logic             pclk_rise,
   output logic             pclk_fall,
   output logic             div_ack,
   output logic             div_pending,
   output logic [DIV_W-1:0] div_cur
);

   // Phase state encoding
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_HIGH = 2'd1;
   localparam logic [1:0] ST_LOW  = 2'd2;

   localparam logic [DIV_W-1:0] MIN_DIV = DIV_W'(2);
   localparam logic [DIV_W-1:0] DEF_DIV = DIV_W'(DEFAULT_DIV);
   localparam logic [DIV_W-2:0] CNT_ONE = (DIV_W-1)'(1);

   logic [1:0]       state_reg, state_next;
   logic [DIV_W-2:0] cnt_reg, cnt_next;
   logic [DIV_W-1:0] div_cur_reg;
   logic [DIV_W-1:0] pend_val_reg;
   logic             pend_reg;
   logic             pclk_reg, rise_reg, fall_reg, ack_reg;

   // Phase limits derived from the active ratio N.
   // floor(N/2) is N without its LSB; ceil(N/2) adds one more for odd N.
   // N >= 2 always holds, so floor(N/2) - 1 never underflows.
   logic [DIV_W-2:0] half_n;
   logic [DIV_W-2:0] low_last;
   logic [DIV_W-2:0] high_last;
   logic [DIV_W-2:0] odd_n;

   assign half_n    = div_cur_reg[DIV_W-1:1];
   assign odd_n     = {{(DIV_W-2){1'b0}}, div_cur_reg[0]};
   assign low_last  = half_n - CNT_ONE;
   assign high_last = low_last + odd_n;

   // Period boundary: last LOW cycle with the clock kept running, or a
   // restart from IDLE. Only here may the ratio change.
   logic boundary;
   logic apply_pending;
   logic [DIV_W-1:0] div_clamped;

   assign boundary      = en & ((state_reg == ST_IDLE) ||
                                ((state_reg == ST_LOW) && (cnt_reg == low_last)));
   assign apply_pending = boundary & pend_reg;

   // Ratios 0 and 1 cannot produce a low phase, so they are raised to 2.
   assign div_clamped   = (div_in < MIN_DIV) ? MIN_DIV : div_in;

   // Next phase state and counter
   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      case (state_reg)
         ST_IDLE: begin
            cnt_next = '0;
            if (en) begin
               state_next = ST_HIGH;
            end
         end
         ST_HIGH: begin
            if (cnt_reg == high_last) begin
               state_next = ST_LOW;
               cnt_next   = '0;
            end else begin
               cnt_next = cnt_reg + CNT_ONE;
            end
         end
         ST_LOW: begin
            if (cnt_reg == low_last) begin
               state_next = en ? ST_HIGH : ST_IDLE;
               cnt_next   = '0;
            end else begin
               cnt_next = cnt_reg + CNT_ONE;
            end
         end
         default: begin
            state_next = ST_IDLE;
            cnt_next   = '0;
         end
      endcase
   end

   // Phase state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= ST_IDLE;
         cnt_reg   <= '0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
      end
   end

   // Pending ratio capture; a new load wins over the clear at a boundary
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_reg     <= 1'b0;
         pend_val_reg <= DEF_DIV;
      end else if (div_load) begin
         pend_reg     <= 1'b1;
         pend_val_reg <= div_clamped;
      end else if (apply_pending) begin
         pend_reg     <= 1'b0;
      end
   end

   // Active ratio: switched only on the boundary edge so the new period
   // uses it from its first HIGH cycle and no period is ever split.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_cur_reg <= DEF_DIV;
      end else if (apply_pending) begin
         div_cur_reg <= pend_val_reg;
      end
   end

   // Registered clock output and strobes, all derived from the next state
   // so they line up with the cycle in which lcd_pclk changes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pclk_reg <= 1'b0;
         rise_reg <= 1'b0;
         fall_reg <= 1'b0;
         ack_reg  <= 1'b0;
      end else begin
         pclk_reg <= (state_next == ST_HIGH);
         rise_reg <= (state_next == ST_HIGH) && (state_reg != ST_HIGH);
         fall_reg <= (state_next == ST_LOW)  && (state_reg == ST_HIGH);
         ack_reg  <= apply_pending;
      end
   end

   assign lcd_pclk    = pclk_reg;
   assign pclk_rise   = rise_reg;
   assign pclk_fall   = fall_reg;
   assign div_ack     = ack_reg;
   assign div_pending = pend_reg;
   assign div_cur     = div_cur_reg;

endmodule

// File: tb/tb_lcd_pclk_gen.sv
// tb_lcd_pclk_gen
// Directed and random stimulus for lcd_pclk_gen. The reference model
// tracks the position inside the current pixel-clock period and derives
// every output from it each cycle.
module tb_lcd_pclk_gen;

   logic       clk;
   logic       rst_n;
   logic       en;
   logic [7:0] div_in;
   logic       div_load;
   logic       lcd_pclk;
   logic       pclk_rise;
   logic       pclk_fall;
   logic       div_ack;
   logic       div_pending;
   logic [7:0] div_cur;

   int n_assert = 0;
   int n_fail   = 0;

   // Reference model state
   int m_run, m_pos, m_n, m_pend, m_pend_val;
   int m_pclk, m_rise, m_fall, m_ack;

   lcd_pclk_gen #(.DIV_W(8), .DEFAULT_DIV(2)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .en          (en),
      .div_in      (div_in),
      .div_load    (div_load),
      .lcd_pclk    (lcd_pclk),
      .pclk_rise   (pclk_rise),
      .pclk_fall   (pclk_fall),
      .div_ack     (div_ack),
      .div_pending (div_pending),
      .div_cur     (div_cur)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_run = 0; m_pos = 0; m_n = 2; m_pend = 0; m_pend_val = 2;
      m_pclk = 0; m_rise = 0; m_fall = 0; m_ack = 0;
   endtask

   // One clk edge of the model: position within an N-cycle period,
   // the high part being the first ceil(N/2) positions.
   task automatic model_step(input bit e, input bit l, input int d);
      bit bnd;
      int prev;
      prev  = m_pclk;
      bnd   = e && (!m_run || (m_pos == m_n - 1));
      m_ack = 0;
      if (bnd) begin
         if (m_pend != 0) begin
            m_n   = m_pend_val;
            m_ack = 1;
         end
         m_run = 1;
         m_pos = 0;
      end else if (m_run != 0) begin
         if (m_pos == m_n - 1) begin
            m_run = 0;
            m_pos = 0;
         end else begin
            m_pos++;
         end
      end
      if (l) begin
         m_pend_val = (d < 2) ? 2 : d;
         m_pend     = 1;
      end else if (bnd) begin
         m_pend = 0;
      end
      m_pclk = (m_run != 0 && m_pos < (m_n + 1) / 2) ? 1 : 0;
      m_rise = (m_pclk == 1 && prev == 0) ? 1 : 0;
      m_fall = (m_pclk == 0 && prev == 1) ? 1 : 0;
   endtask

   task automatic check_all();
      chk("lcd_pclk",    lcd_pclk,    m_pclk);
      chk("pclk_rise",   pclk_rise,   m_rise);
      chk("pclk_fall",   pclk_fall,   m_fall);
      chk("div_ack",     div_ack,     m_ack);
      chk("div_pending", div_pending, m_pend);
      chk("div_cur",     div_cur,     m_n);
   endtask

   // Drive one cycle of inputs from a negedge, update the model at the
   // posedge, check all outputs on the following negedge.
   task automatic cycle(input bit e, input bit l, input int d);
      en       = e;
      div_load = l;
      div_in   = d[7:0];
      if (l) $display("load div_in=%0d en=%0b at %0t", d, e, $time);
      @(posedge clk);
      model_step(e, l, d);
      @(negedge clk);
      check_all();
   endtask

   task automatic timeout(input string tag);
      n_fail++;
      $error("FAIL %s: wait bound expired", tag);
   endtask

   int ack_cnt;
   int k;

   initial begin
      rst_n = 1'b0; en = 1'b0; div_load = 1'b0; div_in = '0;
      model_reset();
      repeat (2) @(negedge clk);
      check_all();
      rst_n = 1'b1;
      @(negedge clk);
      check_all();

      // Default N=2: toggles every cycle, one cycle after en
      cycle(1, 0, 0);
      chk("start_rise", pclk_rise, 1);
      repeat (7) cycle(1, 0, 0);
      chk("default_div", div_cur, 2);

      // Load N=5: single ack, then 3 high / 2 low
      ack_cnt = 0;
      cycle(1, 1, 5);
      for (int i = 0; i < 20; i++) begin
         cycle(1, 0, 0);
         ack_cnt += int'(div_ack);
      end
      chk("ack_once_5", ack_cnt, 1);
      chk("div_cur_5", div_cur, 5);

      // Switch to N=4, then load N=6 in the 2nd high cycle
      cycle(1, 1, 4);
      for (k = 0; k < 20 && m_ack == 0; k++) cycle(1, 0, 0);
      if (k == 20) timeout("wait_ack_4");
      for (k = 0; k < 20 && !(m_run == 1 && m_pos == 1); k++) cycle(1, 0, 0);
      if (k == 20) timeout("wait_high2");
      cycle(1, 1, 6);
      chk("pending_6", div_pending, 1);
      chk("still_4", div_cur, 4);
      repeat (16) cycle(1, 0, 0);
      chk("div_cur_6", div_cur, 6);

      // Drop en in the 1st high cycle of N=6: period completes, then IDLE
      for (k = 0; k < 20 && !(m_run == 1 && m_pos == 0); k++) cycle(1, 0, 0);
      if (k == 20) timeout("wait_high1");
      repeat (12) cycle(0, 0, 0);
      chk("idle_low", lcd_pclk, 0);
      cycle(1, 0, 0);
      chk("restart_rise", pclk_rise, 1);

      // Back-to-back clamped loads: one ack, ratio 2
      ack_cnt = 0;
      cycle(1, 1, 0);
      ack_cnt += int'(div_ack);
      cycle(1, 1, 1);
      ack_cnt += int'(div_ack);
      for (int i = 0; i < 20; i++) begin
         cycle(1, 0, 0);
         ack_cnt += int'(div_ack);
      end
      chk("ack_once_clamp", ack_cnt, 1);
      chk("div_cur_clamp", div_cur, 2);

      // Load on the boundary cycle: pending 3 applied, 5 deferred
      for (k = 0; k < 20 && !(m_run == 1 && m_pos == 0); k++) cycle(1, 0, 0);
      if (k == 20) timeout("wait_pos0");
      cycle(1, 1, 3);
      cycle(1, 1, 5);
      chk("bnd_ack", div_ack, 1);
      chk("bnd_cur", div_cur, 3);
      chk("bnd_pending", div_pending, 1);
      repeat (3) cycle(1, 0, 0);
      chk("deferred_ack", div_ack, 1);
      chk("deferred_cur", div_cur, 5);

      // Async reset mid-HIGH with a ratio pending
      for (k = 0; k < 20 && !(m_run == 1 && m_pos == 0); k++) cycle(1, 0, 0);
      if (k == 20) timeout("wait_pos0_rst");
      cycle(1, 1, 9);
      chk("pre_rst_pclk", lcd_pclk, 1);
      chk("pre_rst_pend", div_pending, 1);
      rst_n = 1'b0;
      #1;
      chk("rst_pclk", lcd_pclk, 0);
      chk("rst_pending", div_pending, 0);
      chk("rst_cur", div_cur, 2);
      model_reset();
      check_all();
      en = 1'b0;
      div_load = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check_all();

      // Random traffic against the model
      for (int i = 0; i < 2500; i++) begin
         bit e, l;
         int d;
         e = ($urandom_range(0, 24) != 0);
         l = ($urandom_range(0, 39) == 0);
         d = ($urandom_range(0, 9) < 8) ? int'($urandom_range(0, 12))
                                        : int'($urandom_range(0, 255));
         cycle(e, l, d);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
